// File: rtl/div_sign_ctrl.sv
// Sign/word control wrapped around the unsigned multicycle divider.
// Define DIV_SPECIAL_FASTPATH_EN to resolve div-by-zero/overflow without the divider.
module div_sign_ctrl (
    input  logic         clk,
    input  logic         resetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [63:0]  a,
    input  logic [63:0]  b,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  result,
    output logic         div_valid,
    output logic [63:0]  div_a,
    output logic [63:0]  div_b,
    input  logic         div_done,
    input  logic [127:0] div_c
);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT, FIX, DONE, DRAIN
    } state_t;

    state_t       state;
    logic [2:0]   op_q;
    logic [63:0]  ea_q;
    logic         sa_q, sb_q, dz_q, ov_q, first_q;
    logic [127:0] c_q;

    logic [63:0]  ea, eb;
    logic         sa, sb, dz, ov;

    always_comb begin
        ea = a;
        eb = b;
        if (op[2]) begin
            ea = op[0] ? {32'b0, a[31:0]} : {{32{a[31]}}, a[31:0]};
            eb = op[0] ? {32'b0, b[31:0]} : {{32{b[31]}}, b[31:0]};
        end
        sa = !op[0] && ea[63];
        sb = !op[0] && eb[63];
        dz = (eb == 64'b0);
        // Word overflow is checked on the sign-extended operands
        ov = !op[0] && (eb == '1) &&
             (ea == (op[2] ? 64'hFFFF_FFFF_8000_0000
                           : 64'h8000_0000_0000_0000));
    end

    function automatic logic [63:0] fixup(
        input logic [2:0]   o,
        input logic [127:0] c,
        input logic         xa,
        input logic         xb,
        input logic         z,
        input logic         v,
        input logic [63:0]  x
    );
        logic [63:0] q, r, s;
        q = c[63:0];
        r = c[127:64];
        if (xa ^ xb) q = -q;
        if (xa)      r = -r;
        if (z) begin
            q = '1;
            r = x;
        end else if (v) begin
            q = x;
            r = 64'b0;
        end
        s = o[1] ? r : q;
        if (o[2]) s = {{32{s[31]}}, s[31:0]};
        return s;
    endfunction

    logic [63:0] fix_res;
    assign fix_res = fixup(op_q, c_q, sa_q, sb_q, dz_q, ov_q, ea_q);

`ifdef DIV_SPECIAL_FASTPATH_EN
    logic [63:0] fast_res;
    assign fast_res = fixup(op, 128'b0, sa, sb, dz, ov, ea);
`endif

    assign in_ready  = (state == IDLE);
    assign div_valid = (state == ISSUE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            op_q    <= 3'b0;
            ea_q    <= 64'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
            first_q <= 1'b0;
            c_q     <= 128'b0;
            div_a   <= 64'b0;
            div_b   <= 64'b0;
            result  <= 64'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!flush && in_valid) begin
                        op_q  <= op;
                        ea_q  <= ea;
                        sa_q  <= sa;
                        sb_q  <= sb;
                        dz_q  <= dz;
                        ov_q  <= ov;
                        div_a <= sa ? -ea : ea;
                        div_b <= sb ? -eb : eb;
`ifdef DIV_SPECIAL_FASTPATH_EN
                        if (dz || ov) begin
                            result <= fast_res;
                            state  <= DONE;
                        end else begin
                            state  <= ISSUE;
                        end
`else
                        state <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    if (flush) begin
                        state <= DRAIN;
                    end else begin
                        first_q <= 1'b1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        state <= DRAIN;
                    end else if (first_q) begin
                        first_q <= 1'b0;
                    end else if (div_done) begin
                        c_q   <= div_c;
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        result <= fix_res;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (flush || out_ready) state <= IDLE;
                end
                DRAIN: begin
                    if (flush || div_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sign_ctrl.sv
// Scoreboard bench for div_sign_ctrl with a behavioural fixed-latency divider.
module tb_div_sign_ctrl;

    localparam int L  = 4;
    localparam int NL = L + 3;
`ifdef DIV_SPECIAL_FASTPATH_EN
    localparam int SL = 1;
    localparam bit FP = 1'b1;
`else
    localparam int SL = NL;
    localparam bit FP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = 3'b0;
    logic [63:0]  a = 64'b0, b = 64'b0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [63:0]  result;
    logic         div_valid;
    logic [63:0]  div_a, div_b;
    logic         div_done;
    logic [127:0] div_c;

    div_sign_ctrl dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result),
        .div_valid(div_valid), .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_c(div_c)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider model: done is high L cycles after the div_valid cycle
    logic [63:0] ma = 64'b0, mb = 64'b0;
    int          cnt = 0;
    always @(posedge clk) begin
        if (!resetn) begin
            cnt <= 0;
        end else if (div_valid) begin
            cnt <= L;
            ma  <= div_a;
            mb  <= div_b;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
        end
    end
    always_comb begin
        div_done = (cnt == 1);
        div_c = {(mb == 0) ? ma : ma % mb,
                 (mb == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ma / mb};
    end

    typedef struct {
        logic [63:0] exp;
        int          lat;
        int          stall;
        longint      acc;
    } item_t;
    item_t sbq[$];

    int nvec = 0;
    int nerr = 0;
    int dv_seen = 0;
    int dv_exp = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) if (resetn && div_valid) dv_seen++;

    // Monitor: compare every cycle out_valid is up, pop on handshake
    initial begin
        bit pv = 1'b0;
        bit after = 1'b0;
        int sc = 0;
        forever begin
            @(negedge clk);
            if (after) begin
                check("in_ready_after_hs", {63'b0, in_ready}, 64'd1);
                check("out_valid_drop", {63'b0, out_valid}, 64'd0);
                after = 1'b0;
            end
            if (resetn && out_valid) begin
                if (sbq.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_out_valid: got %h expected none",
                             result);
                    out_ready = 1'b1;
                end else begin
                    if (!pv) begin
                        check("latency", 64'(cyc - sbq[0].acc),
                              64'(sbq[0].lat));
                        sc = sbq[0].stall;
                    end
                    check("result", result, sbq[0].exp);
                    out_ready = (sc == 0);
                    if (sc > 0) sc--;
                    if (out_ready) begin
                        void'(sbq.pop_front());
                        after = 1'b1;
                    end
                end
            end else begin
                out_ready = 1'b0;
            end
            pv = resetn && out_valid;
        end
    end

    longint acc_last = 0;

    task automatic issue(input logic [2:0] o, input logic [63:0] x,
                         input logic [63:0] y, input logic [63:0] e,
                         input bit spc, input int st, input bit push);
        int t = 0;
        item_t it;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            nvec++;
            nerr++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        acc_last = cyc;
        if (!(FP && spc)) dv_exp++;
        if (push) begin
            it.exp = e;
            it.lat = spc ? SL : NL;
            it.stall = st;
            it.acc = cyc;
            sbq.push_back(it);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_div_valid", {63'b0, div_valid}, 64'd0);
        check("rst_div_a", div_a, 64'd0);
        check("rst_div_b", div_b, 64'd0);
        resetn = 1'b1;

        issue(3'b000, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0, 1);
        issue(3'b010, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1);
        issue(3'b001, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1);
        issue(3'b011, 64'd100, 64'd0, 64'd100, 1, 0, 1);
        issue(3'b000, 64'h8000_0000_0000_0000, '1,
              64'h8000_0000_0000_0000, 1, 0, 1);
        issue(3'b010, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0, 1);
        issue(3'b100, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF,
              64'hFFFF_FFFF_8000_0000, 1, 0, 1);
        issue(3'b111, 64'h1_0000_0007, 64'd2, 64'd1, 0, 0, 1);
        issue(3'b100, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0, 1);
        issue(3'b110, 64'h8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 1, 0, 1);

        // Flush in the third WAIT cycle: drains the divider, no result
        issue(3'b001, 64'd50, 64'd7, 64'd0, 0, 0, 0);
        while (cyc < acc_last + 4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("drain_in_ready", {63'b0, in_ready}, 64'd0);
        @(negedge clk);
        check("drain_release", {63'b0, in_ready}, 64'd1);
        issue(3'b001, 64'd10, 64'd3, 64'd3, 0, 0, 1);

        issue(3'b000, 64'd20, 64'd4, 64'd5, 0, 5, 1);

        for (int i = 0; i < 300 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     sbq.size());
        end
        repeat (3) @(negedge clk);
        check("div_valid_pulses", 64'(dv_seen), 64'(dv_exp));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/div_sign_ctrl.md
# div_sign_ctrl

Control stage wrapped around the unsigned multicycle divider in the execute unit. Accepts RV64M divide/remainder ops (DIV, DIVU, REM, REMU and the W forms) from the execute pipeline. Converts the operands to unsigned magnitudes, launches the divider, and waits for completion. Applies sign and word fix-ups plus RISC-V special-case results, then holds the result until the downstream stage accepts it.

## Interface
Parameters:
- none (widths fixed at 64-bit datapath)

Ports:
- clk  in  1  clock
- resetn  in  1  reset: synchronous, active-low
- in_valid  in  1  op offered by execute pipeline
- in_ready  out  1  block can accept op; high iff state IDLE
- op  in  3  op[0]=unsigned, op[1]=remainder, op[2]=word (32-bit) variant
- a, b  in  64  dividend, divisor
- flush  in  1  discard in-flight op
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- result  out  64  quotient or remainder
- div_valid  out  1  start pulse to divider
- div_a, div_b  out  64  unsigned magnitudes to divider
- div_done  in  1  divider completion
- div_c  in  128  divider output {remainder, quotient}

## Operation
- States: IDLE, ISSUE, WAIT, FIX, DONE, DRAIN.
- IDLE: on in_valid, register op, register the extended operands and the special-case flags, then go to ISSUE. Special case with the fast path enabled: go to DONE instead.
- Operand extension:
  - Word ops: a, b taken from bits [31:0]. Signed word ops sign-extend to 64 bits; unsigned word ops zero-extend.
- Magnitudes:
  - Signed ops: |x| = x[63] ? -x : x. MIN (0x8000_0000_0000_0000) maps to 2^63.
  - Unsigned ops: operands passed unchanged.
- ISSUE: div_valid=1 for exactly one cycle; div_a and div_b stable from ISSUE until capture. Next state WAIT.
- WAIT: div_done is ignored in the first WAIT cycle. Thereafter, on div_done, capture div_c and go to FIX.
- FIX:
  - Quotient is negated if sign_a^sign_b for signed ops. Remainder is negated if sign_a.
  - Select quotient or remainder by op[1].
  - Word ops sign-extend bit 31 of the selected value.
  - Special-case overrides win over the computed value. Result is registered; go to DONE.
- Special cases (after extension):
  - b==0: quotient = all-ones, remainder = a.
  - Signed overflow (a==MIN, b==-1, at 64 or 32 bits): quotient = a, remainder = 0.
  - Word results are still sign-extended from bit 31.
- DONE: out_valid=1 and result stable. On out_ready go to IDLE.
- flush:
  - In ISSUE or WAIT: go to DRAIN.
  - In any other state: go to IDLE next cycle.
  - DRAIN waits for div_done (first-cycle rule does not apply), discards the output, then goes to IDLE.
  - flush has priority over div_done and out_ready.
- Reset (resetn=0 at clk edge):
  - Outputs after reset: state IDLE, out_valid=0, result=0, div_valid=0, div_a=div_b=0, in_ready=1.
  - Reset mid-operation abandons the op. The divider is assumed reset by the same resetn.

## Timing
- Accept on cycle 0 (IDLE & in_valid).
- Normal op: div_valid in cycle 1, WAIT from cycle 2, FIX in the cycle after div_done is sampled, out_valid the cycle after FIX. Total latency = divider latency + 3.
- Fast-path special case: out_valid at cycle 1.
- No new op is accepted in the same cycle out_valid falls. in_ready rises the cycle after the out_ready handshake.
- result is held constant while out_valid=1 and out_ready=0.

## Configuration
- DIV_SPECIAL_FASTPATH_EN defined: divide-by-zero and signed overflow skip the divider; IDLE→DONE, 1-cycle latency, div_valid never asserted for them.
- Undefined: all ops go through ISSUE/WAIT/FIX. Overrides are applied in FIX with full divider latency. Result values are identical in both builds.

## Test plan
- DIV a=-7, b=2 → result 0xFFFF_FFFF_FFFF_FFFD (-3). REM on the same operands → 0xFFFF_FFFF_FFFF_FFFF (-1).
- DIVU a=100, b=0 → 0xFFFF_FFFF_FFFF_FFFF; REMU → 100.
  - Macro defined: out_valid cycle 1, div_valid never high.
  - Macro undefined: full latency.
- DIV a=0x8000_0000_0000_0000, b=-1 → 0x8000_0000_0000_0000; REM → 0.
- DIVW a=0x0000_0000_8000_0000, b=0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000. REMUW a=0x1_0000_0007, b=2 → 1.
- flush in the 3rd WAIT cycle:
  - in_ready stays 0 until div_done; no out_valid.
  - Next op DIVU 10/3 returns 3.
- DIV 20/4 with out_ready held low 5 cycles after out_valid → result=5 stable throughout, single handshake, in_ready rises the following cycle.
